bid_arbiter: RTL and testbench

BID_ARBITER -- requirements
Module: bid_arbiter

---
 rtl/bid_arbiter_pkg.sv | 15 +
 rtl/bid_select.sv | 37 +++
 rtl/bid_arbiter.sv | 130 +++++++++++++
 tb/tb_bid_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bid_arbiter_pkg.sv
// Shared types and widths for the bid arbiter.
// Bids are 4 bits wide; 0 means "no request".
package bid_arbiter_pkg;

    localparam int BID_W  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

endpackage

// File: rtl/bid_select.sv
// Combinational max-bid search; ties go to the first master at or after i_start.
// Zero latency, no backpressure.
module bid_select
    import bid_arbiter_pkg::*;
#(
    parameter int NM    = 4,
    parameter int IDX_W = 2
) (
    input  logic [NM*BID_W-1:0] i_req,
    input  logic [IDX_W-1:0]    i_start,
    output logic [IDX_W-1:0]    o_winner,
    output logic                o_any
);

    logic [BID_W-1:0] w_best;
    int               w_idx;

    // Strict greater-than while walking in rotated order keeps the earliest tied master.
    always_comb begin
        w_best   = '0;
        w_idx    = 0;
        o_winner = i_start;
        o_any    = 1'b0;
        for (int k = 0; k < NM; k++) begin
            w_idx = int'(i_start) + k;
            if (w_idx >= NM) begin
                w_idx = w_idx - NM;
            end
            if (i_req[w_idx*BID_W +: BID_W] > w_best) begin
                w_best   = i_req[w_idx*BID_W +: BID_W];
                o_winner = IDX_W'(w_idx);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bid_arbiter.sv
// Bid-based single-slave bus arbiter: 1-cycle arbitration, grant held until xfr
// drops, wait timeout or length limit; slave-side mux is purely combinational.
module bid_arbiter
    import bid_arbiter_pkg::*;
#(
    parameter int NM     = 4,
    parameter int GNT_TO = 4,
    parameter int MAXLEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM*BID_W-1:0] req,
    output logic [NM-1:0]       grant,
    input  logic [NM-1:0]       xfr,
    input  logic [NM-1:0]       RW,
    input  logic [NM*ADDR_W-1:0] addr,
    input  logic [NM*DATA_W-1:0] DataToSlave,
    output logic [NM*DATA_W-1:0] DataFromSlave,
    output logic                s_xfr,
    output logic                s_RW,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam int IDX_W  = (NM > 1) ? $clog2(NM) : 1;
    localparam int WAIT_W = $clog2(GNT_TO + 1);
    localparam int LEN_W  = $clog2(MAXLEN + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_winner;
    logic [IDX_W-1:0]   r_last;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_latch;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_sel;
    logic               w_any;
    logic               w_granted;
    logic               w_xfr_win;

    assign w_start   = (r_last == IDX_W'(NM - 1)) ? '0 : r_last + 1'b1;
    assign w_granted = (r_state != ST_IDLE);
    assign w_xfr_win = xfr[r_winner];

    bid_select #(
        .NM    (NM),
        .IDX_W (IDX_W)
    ) u_bid_select (
        .i_req    (req),
        .i_start  (w_start),
        .o_winner (w_sel),
        .o_any    (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_winner <= '0;
            r_last   <= IDX_W'(NM - 1);
            r_wait   <= '0;
            r_len    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_len   <= w_len_nxt;
            if (w_latch) begin
                r_winner <= w_sel;
                r_last   <= w_sel;
            end
        end
    end

    // The cycle in GRANT where xfr first rises already counts toward MAXLEN.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_len_nxt   = r_len;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_GRANT;
                    w_wait_nxt  = '0;
                    w_len_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_xfr_win) begin
                    w_len_nxt   = LEN_W'(1);
                    w_state_nxt = (MAXLEN == 1) ? ST_IDLE : ST_XFER;
                end else if (r_wait == WAIT_W'(GNT_TO - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            ST_XFER: begin
                if (!w_xfr_win || r_len == LEN_W'(MAXLEN - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_len_nxt = r_len + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant         = '0;
        DataFromSlave = '0;
        s_xfr         = 1'b0;
        s_RW          = 1'b0;
        s_addr        = '0;
        s_wdata       = '0;
        if (w_granted) begin
            grant[r_winner] = 1'b1;
            DataFromSlave[int'(r_winner)*DATA_W +: DATA_W] = s_rdata;
            s_xfr   = w_xfr_win;
            s_RW    = RW[r_winner];
            s_addr  = addr[int'(r_winner)*ADDR_W +: ADDR_W];
            s_wdata = DataToSlave[int'(r_winner)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_bid_arbiter.sv
// Directed-vector bench for bid_arbiter with hand-computed expectations.
module tb_bid_arbiter;

    localparam int NM = 4;

    logic           clk;
    logic           rst;
    logic [15:0]    req;
    logic [3:0]     grant;
    logic [3:0]     xfr;
    logic [3:0]     RW;
    logic [127:0]   addr;
    logic [127:0]   DataToSlave;
    logic [127:0]   DataFromSlave;
    logic           s_xfr;
    logic           s_RW;
    logic [31:0]    s_addr;
    logic [31:0]    s_wdata;
    logic [31:0]    s_rdata;

    int n_vec;
    int n_err;
    int cnt;

    bid_arbiter #(
        .NM     (NM),
        .GNT_TO (4),
        .MAXLEN (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .grant         (grant),
        .xfr           (xfr),
        .RW            (RW),
        .addr          (addr),
        .DataToSlave   (DataToSlave),
        .DataFromSlave (DataFromSlave),
        .s_xfr         (s_xfr),
        .s_RW          (s_RW),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        cnt         = 0;
        rst         = 1'b1;
        req         = '0;
        xfr         = '0;
        RW          = '0;
        addr        = '0;
        DataToSlave = '0;
        s_rdata     = 32'h5555_AAAA;

        #3;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_s_xfr", 64'(s_xfr), 64'h0);
        chk("rst_s_addr", 64'(s_addr), 64'h0);
        chk("rst_dfs", 64'(DataFromSlave[63:0]), 64'h0);
        step();
        step();
        rst = 1'b0;

        // Highest bid with rotating tie-break: bids m3..m0 = 3,9,9,1
        req = 16'h3991;
        step();
        chk("tie_first", 64'(grant), 64'b0010);
        xfr = 4'b0010;
        step();
        xfr = 4'b0000;
        step();
        chk("tie_release", 64'(grant), 64'b0000);
        step();
        chk("tie_second", 64'(grant), 64'b0100);
        xfr = 4'b0100;
        step();
        xfr = 4'b0000;
        req = '0;
        step();
        chk("tie_rel2", 64'(grant), 64'b0000);
        step();
        chk("idle_noreq", 64'(grant), 64'b0000);

        // Single request, three transfer cycles
        req = 16'h0500;
        step();
        chk("single_grant", 64'(grant), 64'b0100);
        chk("single_noxfr", 64'(s_xfr), 64'h0);
        req = '0;
        xfr = 4'b0100;
        #1;
        chk("single_x1", 64'(s_xfr), 64'h1);
        step();
        chk("single_x2", 64'(s_xfr), 64'h1);
        step();
        chk("single_x3", 64'(s_xfr), 64'h1);
        xfr = 4'b0000;
        #1;
        chk("single_x_end", 64'(s_xfr), 64'h0);
        chk("single_hold", 64'(grant), 64'b0100);
        step();
        chk("single_drop", 64'(grant), 64'b0000);

        // Grant timeout
        req = 16'h0001;
        step();
        chk("to_grant", 64'(grant), 64'b0001);
        req = '0;
        step();
        step();
        step();
        chk("to_cycle4", 64'(grant), 64'b0001);
        step();
        chk("to_drop", 64'(grant), 64'b0000);
        step();
        chk("to_idle", 64'(grant), 64'b0000);

        // Length limit with xfr held high
        req = 16'h0010;
        step();
        chk("len_grant", 64'(grant), 64'b0010);
        xfr = 4'b0010;
        cnt = 0;
        #1;
        for (int k = 0; k < 16; k++) begin
            cnt += int'(s_xfr);
            if (k == 15) chk("len_last", 64'(grant), 64'b0010);
            step();
        end
        chk("len_drop", 64'(grant), 64'b0000);
        chk("len_count", 64'(cnt), 64'd16);
        step();
        chk("len_regrant", 64'(grant), 64'b0010);
        xfr = '0;
        req = '0;
        for (int k = 0; k < 5; k++) step();
        chk("len_cleanup", 64'(grant), 64'b0000);

        // Mux and isolation
        addr[3*32 +: 32]        = 32'h0000_1000;
        DataToSlave[3*32 +: 32] = 32'hDEAD_BEEF;
        addr[0*32 +: 32]        = 32'h0000_BAD0;
        DataToSlave[0*32 +: 32] = 32'h1234_5678;
        RW  = 4'b1000;
        req = 16'hF000;
        step();
        chk("mux_grant", 64'(grant), 64'b1000);
        xfr = 4'b0001;
        #1;
        chk("mux_iso_xfr", 64'(s_xfr), 64'h0);
        chk("mux_addr", 64'(s_addr), 64'h1000);
        chk("mux_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("mux_rw", 64'(s_RW), 64'h1);
        xfr     = 4'b1001;
        s_rdata = 32'hCAFE_F00D;
        #1;
        chk("mux_xfr", 64'(s_xfr), 64'h1);
        chk("mux_dfs0", 64'(DataFromSlave[0*32 +: 32]), 64'h0);
        chk("mux_dfs3", 64'(DataFromSlave[3*32 +: 32]), 64'hCAFE_F00D);

        // Reset mid-transfer
        step();
        chk("rstx_pre", 64'(grant), 64'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("rstx_grant", 64'(grant), 64'b0000);
        chk("rstx_s_xfr", 64'(s_xfr), 64'h0);
        chk("rstx_s_addr", 64'(s_addr), 64'h0);
        chk("rstx_dfs3", 64'(DataFromSlave[3*32 +: 32]), 64'h0);
        #2;
        rst = 1'b0;
        xfr = '0;
        req = 16'h1111;
        step();
        chk("rstx_rearb", 64'(grant), 64'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
